// File: rtl/risc_pkg.sv
// Shared encodings for the issue scheduler: opcodes, register names, bubble word, FSM states.
// The decode helpers are shared so every hazard comparator reads the same instruction semantics.
package risc_pkg;

  localparam logic [1:0] LW   = 2'b11;
  localparam logic [1:0] SW   = 2'b10;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] NOOP = 2'b00;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam logic [7:0] NOOP_INSTR = 8'h00;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  function automatic logic op_writes(input logic [1:0] op);
    return (op == LW) || (op == ADD);
  endfunction

  function automatic logic op_reads_a(input logic [1:0] op);
    return (op == ADD) || (op == SW);
  endfunction

  function automatic logic op_reads_b(input logic [1:0] op);
    return (op == ADD) || (op == SW) || (op == LW);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// RAW check of one candidate instruction against one in-flight slot.
// The slot is passed as opcode plus destination field; nothing else of it matters here.
module hazard_cmp
  import risc_pkg::*;
(
  input  logic [7:0] cand,
  input  logic [1:0] slot_op,
  input  logic [2:0] slot_dst,
  output logic       hit
);

  logic [1:0] cand_op;
  logic [2:0] cand_a;
  logic [2:0] cand_b;

  assign cand_op = cand[7:6];
  assign cand_a  = cand[5:3];
  assign cand_b  = cand[2:0];

  assign hit = op_writes(slot_op) &&
               ((op_reads_a(cand_op) && (cand_a == slot_dst)) ||
                (op_reads_b(cand_op) && (cand_b == slot_dst)));

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue of a loaded program into a 5-stage pipeline, inserting bubbles on RAW
// hazards against the two most recently issued instructions.
//
// state | meaning
// IDLE  | buffer empty, waiting for first write
// LOAD  | accepting program words
// RUN   | issuing one instruction or bubble per cycle
// DRAIN | pipeline emptying, nothing issued
// DONE  | program finished, results held
module issue_scheduler
  import risc_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       start,
  input  logic       clear,
  output logic       issue_valid,
  output logic [7:0] issue_instr,
  output logic       bubble,
  output logic [7:0] stall_cnt,
  output logic       busy,
  output logic       done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] ptr, ptr_nxt;
  logic [4:0]    s1, s1_nxt;
  logic [4:0]    s2, s2_nxt;
  logic [7:0]    stall_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [7:0]    mem [DEPTH];

  logic       wr_en;
  logic [7:0] cand;
  logic       hit1, hit2, hazard;

  assign in_ready = ((state == IDLE) || (state == LOAD)) && (count < CW'(DEPTH));
  assign wr_en    = in_valid && in_ready && !clear;
  assign cand     = mem[ptr[AW-1:0]];

  // Slots keep opcode and field A only: that is all a later reader can collide with.
  hazard_cmp u_cmp_s1 (
    .cand     (cand),
    .slot_op  (s1[4:3]),
    .slot_dst (s1[2:0]),
    .hit      (hit1)
  );

  hazard_cmp u_cmp_s2 (
    .cand     (cand),
    .slot_op  (s2[4:3]),
    .slot_dst (s2[2:0]),
    .hit      (hit2)
  );

  assign hazard      = hit1 || hit2;
  assign issue_valid = (state == RUN);
  assign bubble      = (state == RUN) && hazard;
  assign issue_instr = ((state == RUN) && !hazard) ? cand : NOOP_INSTR;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      ptr       <= '0;
      s1        <= '0;
      s2        <= '0;
      stall_cnt <= '0;
      tmr       <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      ptr       <= ptr_nxt;
      s1        <= s1_nxt;
      s2        <= s2_nxt;
      stall_cnt <= stall_nxt;
      tmr       <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ptr_nxt   = ptr;
    s1_nxt    = s1;
    s2_nxt    = s2;
    stall_nxt = stall_cnt;
    tmr_nxt   = tmr;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      ptr_nxt   = '0;
      s1_nxt    = '0;
      s2_nxt    = '0;
      stall_nxt = '0;
      tmr_nxt   = '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (wr_en) begin
            count_nxt = count + CW'(1);
            state_nxt = LOAD;
          end
          // A write in the same cycle as start still belongs to this program.
          if (start && ((count != '0) || wr_en)) begin
            state_nxt = RUN;
            ptr_nxt   = '0;
            s1_nxt    = '0;
            s2_nxt    = '0;
            stall_nxt = '0;
          end
        end
        RUN: begin
          s2_nxt = s1;
          s1_nxt = issue_instr[7:3];
          if (hazard) begin
            if (stall_cnt != 8'hFF) stall_nxt = stall_cnt + 8'd1;
          end else begin
            ptr_nxt = ptr + CW'(1);
            if (ptr == count - CW'(1)) begin
              state_nxt = DRAIN;
              tmr_nxt   = TW'(DRAIN_CYC - 1);
            end
          end
        end
        DRAIN: begin
          if (tmr == '0) state_nxt = DONE;
          else tmr_nxt = tmr - TW'(1);
        end
        DONE: begin
          if (start) begin
            state_nxt = RUN;
            ptr_nxt   = '0;
            s1_nxt    = '0;
            s2_nxt    = '0;
            stall_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus random programs
// compared against a register-mask reference model of the issue stream.
module tb_issue_scheduler;

  localparam int DEPTH     = 8;
  localparam int DRAIN_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       in_ready;
  logic       issue_valid;
  logic [7:0] issue_instr;
  logic       bubble;
  logic [7:0] stall_cnt;
  logic       busy;
  logic       done;

  issue_scheduler #(.DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .start       (start),
    .clear       (clear),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .bubble      (bubble),
    .stall_cnt   (stall_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] prog[$];
  logic [8:0] exp_q[$];
  int         exp_stalls;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wmask(input logic [7:0] x);
    if (x[7:6] == 2'b11 || x[7:6] == 2'b01) return 8'h01 << x[5:3];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rmask(input logic [7:0] x);
    case (x[7:6])
      2'b01, 2'b10: return (8'h01 << x[5:3]) | (8'h01 << x[2:0]);
      2'b11:        return 8'h01 << x[2:0];
      default:      return 8'h00;
    endcase
  endfunction

  // Expected stream: each entry is {bubble, instr}.
  task automatic build_model();
    logic [7:0] w1, w2;
    int stalls;
    exp_q.delete();
    w1 = 8'h00;
    w2 = 8'h00;
    stalls = 0;
    foreach (prog[i]) begin
      while ((rmask(prog[i]) & (w1 | w2)) != 8'h00) begin
        exp_q.push_back({1'b1, 8'h00});
        stalls++;
        w2 = w1;
        w1 = 8'h00;
      end
      exp_q.push_back({1'b0, prog[i]});
      w2 = w1;
      w1 = wmask(prog[i]);
    end
    exp_stalls = (stalls > 255) ? 255 : stalls;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_and_start(input bit start_with_last);
    for (int i = 0; i < prog.size(); i++) begin
      in_valid = 1'b1;
      in_data  = prog[i];
      start    = start_with_last && (i == prog.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!start_with_last) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic collect(input string tag);
    int  n_issue = 0;
    int  drain = 0;
    int  idle_bad = 0;
    int  cyc = 0;
    bit  got_done = 1'b0;
    while (!got_done && cyc < 200) begin
      if (issue_valid) begin
        if (n_issue < exp_q.size())
          check_eq({tag, " issue"}, {23'd0, bubble, issue_instr}, {23'd0, exp_q[n_issue]});
        n_issue++;
      end else begin
        if (issue_instr !== 8'h00 || bubble !== 1'b0) idle_bad++;
        if (busy) drain++;
      end
      if (done) got_done = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    check_eq({tag, " done"}, got_done, 1);
    check_eq({tag, " n_issue"}, n_issue, exp_q.size());
    check_eq({tag, " drain"}, drain, DRAIN_CYC);
    check_eq({tag, " stall_cnt"}, stall_cnt, exp_stalls);
    check_eq({tag, " idle_out"}, idle_bad, 0);
    check_eq({tag, " busy_at_done"}, busy, 0);
  endtask

  task automatic run_case(input string tag, input bit start_with_last);
    do_clear();
    build_model();
    load_and_start(start_with_last);
    collect(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " in_ready"}, in_ready, 1);
    check_eq({tag, " issue_valid"}, issue_valid, 0);
    check_eq({tag, " issue_instr"}, issue_instr, 0);
    check_eq({tag, " bubble"}, bubble, 0);
    check_eq({tag, " busy"}, busy, 0);
    check_eq({tag, " done"}, done, 0);
    check_eq({tag, " stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    int cyc;
    bit saw_done;
    #2;
    check_idle_outputs("reset");
    #20 rst_n = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // start with an empty buffer is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("empty_start busy", busy, 0);

    prog = '{8'h4A, 8'h59};
    run_case("dep_s1", 1'b0);
    check_eq("dep_s1 stalls_const", stall_cnt, 2);

    // rerun from DONE restarts at index 0 with a fresh stall count
    start = 1'b1;
    tick();
    start = 1'b0;
    collect("rerun");

    prog = '{8'h4A, 8'h53, 8'h59};
    run_case("dep_s2", 1'b0);
    check_eq("dep_s2 stalls_const", stall_cnt, 1);

    prog = '{8'hE5, 8'hA6};
    run_case("lw_sw", 1'b0);
    prog = '{8'h53, 8'h6E, 8'hA6};
    run_case("no_dep", 1'b0);
    check_eq("no_dep stalls_const", stall_cnt, 0);

    prog = '{8'h4A, 8'h59};
    run_case("same_cycle_start", 1'b1);

    // overfill: the ninth word must be refused
    do_clear();
    prog.delete();
    for (int i = 0; i < DEPTH + 1; i++) prog.push_back(8'($urandom));
    for (int i = 0; i < DEPTH + 1; i++) begin
      check_eq($sformatf("fill in_ready %0d", i), in_ready, (i < DEPTH) ? 1 : 0);
      in_valid = 1'b1;
      in_data  = prog[i];
      tick();
    end
    in_valid = 1'b0;
    void'(prog.pop_back());
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    collect("overfill");

    // async reset after two issue cycles
    do_clear();
    prog = '{8'h4A, 8'h53, 8'h59};
    load_and_start(1'b0);
    check_eq("rst_run issue0", issue_valid, 1);
    tick();
    check_eq("rst_run issue1", issue_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid_run");
    tick();
    #1 rst_n = 1'b1;
    tick();
    check_idle_outputs("rst_release");

    // clear during DRAIN
    prog = '{8'h4A};
    do_clear();
    load_and_start(1'b0);
    cyc = 0;
    while (!(busy && !issue_valid) && cyc < 50) begin
      tick();
      cyc++;
    end
    check_eq("drain reached", busy && !issue_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_outputs("clear_drain");
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check_eq("clear_drain no_done", saw_done, 0);

    // random programs
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
      run_case($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
